mybusmatrix5x7_in_stage: RTL

- Per-master input stage of the 5x7 bus matrix; one instance per master port.
- Sits between an AHB master and the address decoder / per-slave output arbiters.
- When the target output arbiter does not grant this port, it registers the master's address phase and stalls the master with HREADYOUTS low. It then replays the held transfer to the decoder until the transfer is accepted.
- Tracks the data phase of accepted transfers and returns the slave's ready and response to the master.

---
 rtl/mybusmatrix5x7_in_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/mybusmatrix5x7_in_stage.sv
// rtl/mybusmatrix5x7_in_stage.sv - per-master input stage of the 5x7 bus matrix
// Holds an ungranted address phase and replays it until accepted, then tracks its data phase.
module mybusmatrix5x7_in_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  accept,
  input  logic                  readyout_dp,
  input  logic                  resp_dp,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  sel_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [1:0]            trans_out,
  output logic                  write_out,
  output logic [2:0]            size_out,
  output logic [2:0]            burst_out,
  output logic [3:0]            prot_out,
  output logic                  lock_out,
  output logic                  ready_out
);

  logic                  pend;
  logic                  dp_active;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [1:0]            hold_trans;
  logic                  hold_write;
  logic [2:0]            hold_size;
  logic [2:0]            hold_burst;
  logic [3:0]            hold_prot;
  logic                  hold_lock;

  logic new_req;
  logic granted;

  assign new_req = HSELS & HREADYS & HTRANSS[1];
  assign granted = pend ? accept : (new_req & accept);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend       <= 1'b0;
      dp_active  <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= '0;
      hold_write <= 1'b0;
      hold_size  <= '0;
      hold_burst <= '0;
      hold_prot  <= '0;
      hold_lock  <= 1'b0;
    end else begin
      if (pend) begin
        if (accept) pend <= 1'b0;
      end else if (new_req && !accept) begin
        pend       <= 1'b1;
        hold_addr  <= HADDRS;
        hold_trans <= HTRANSS;
        hold_write <= HWRITES;
        hold_size  <= HSIZES;
        hold_burst <= HBURSTS;
        hold_prot  <= HPROTS;
        hold_lock  <= HMASTLOCKS;
      end
      // A transfer accepted this cycle keeps the data phase busy even if the previous one ends.
      if (granted) begin
        dp_active <= 1'b1;
      end else if (dp_active && readyout_dp) begin
        dp_active <= 1'b0;
      end
    end
  end

  always_comb begin
    sel_out   = HSELS & HTRANSS[1];
    ready_out = HREADYS;
    addr_out  = HADDRS;
    trans_out = HTRANSS;
    write_out = HWRITES;
    size_out  = HSIZES;
    burst_out = HBURSTS;
    prot_out  = HPROTS;
    lock_out  = HMASTLOCKS;
    if (pend) begin
      sel_out   = 1'b1;
      ready_out = 1'b1;
      addr_out  = hold_addr;
      trans_out = 2'b10;
      write_out = hold_write;
      size_out  = hold_size;
      // Replay may start mid-burst, so fixed-length bursts degrade to INCR.
      burst_out = (|hold_burst[2:1]) ? 3'b001 : hold_burst;
      prot_out  = hold_prot;
      lock_out  = hold_lock;
    end
  end

  assign HREADYOUTS = pend ? 1'b0 : (dp_active ? readyout_dp : 1'b1);
  assign HRESPS     = (dp_active & ~pend) ? resp_dp : 1'b0;

endmodule
